// File: rtl/mcycle_ctrl_if.sv
// Controller <-> datapath/memory bundle for mcycle_ctrl.
// master = controller (drives strobes and status), slave = datapath/memory side.
interface mcycle_ctrl_if #(
  parameter int DEPTH = 16
);
  localparam int DW = $clog2(DEPTH + 1);

  logic [3:0]    ir1;
  logic [2:0]    ir2;
  logic          dcond;
  logic          mem_rdy;

  logic          memwr;
  logic          memrd;
  logic          tmar;
  logic          ldmar;
  logic          tmdr;
  logic          ldmdr;
  logic          rd;
  logic          wr;
  logic          tsp;
  logic          ldsp;
  logic          tpc;
  logic          ldpc;
  logic          tir;
  logic          ldir;
  logic          ldt;
  logic          m1;
  logic          m2;
  logic [2:0]    fnsel;
  logic [DW-1:0] depth;
  logic          halt;
  logic [1:0]    err;

  modport master (
    input  ir1, ir2, dcond, mem_rdy,
    output memwr, memrd, tmar, ldmar, tmdr, ldmdr, rd, wr, tsp, ldsp,
           tpc, ldpc, tir, ldir, ldt, m1, m2, fnsel, depth, halt, err
  );

  modport slave (
    output ir1, ir2, dcond, mem_rdy,
    input  memwr, memrd, tmar, ldmar, tmdr, ldmdr, rd, wr, tsp, ldsp,
           tpc, ldpc, tir, ldir, ldt, m1, m2, fnsel, depth, halt, err
  );
endinterface

// File: rtl/mcycle_ctrl.sv
// Multi-cycle controller: fetch/decode, branch, CALL/PUSH/POP sequencing with stack-depth
// tracking, per-access memory wait timeout and a sticky error halt. Outputs are registered.
module mcycle_ctrl #(
  parameter int DEPTH = 16,
  parameter int TMO   = 15
) (
  input logic           clk,
  input logic           rst_n,
  mcycle_ctrl_if.master bus
);
  localparam int DW = $clog2(DEPTH + 1);

  localparam logic [2:0]    FN_ADD    = 3'b000;
  localparam logic [2:0]    FN_INC    = 3'b100;
  localparam logic [2:0]    FN_DEC    = 3'b101;
  localparam logic [2:0]    FN_PASS   = 3'b110;
  localparam logic [2:0]    FN_PASSB  = 3'b111;
  localparam logic [7:0]    TMO_LAST  = 8'(TMO - 1);
  localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);
  localparam logic [DW-1:0] DEPTH_ONE = DW'(1);

  typedef enum logic [4:0] {
    S_RST, S_FETCH0, S_FETCH1, S_IRLD, S_DECODE, S_INCPC, S_SPINC,
    S_MDRLD_PC, S_MDRLD_R, S_MARSP, S_MEMWR, S_BRT, S_BRPC,
    S_MEMRD, S_MDRLD_M, S_TLD, S_SPDEC, S_POPR, S_RET, S_ALU, S_ERR
  } state_t;

  typedef enum logic [1:0] {C_BR, C_CALL, C_PUSH, C_POP} cls_t;

  typedef struct packed {
    logic memwr, memrd, tmar, ldmar, tmdr, ldmdr, rd, wr, tsp;
    logic ldsp, tpc, ldpc, tir, ldir, ldt, m1, m2;
    logic [2:0] fnsel;
  } ctl_t;

  state_t        state_q, state_d;
  cls_t          cls_q, cls_d, dec_cls;
  logic [2:0]    sub_q, sub_d;
  logic [7:0]    wcnt_q, wcnt_d;
  logic [DW-1:0] depth_q, depth_d;
  logic [1:0]    err_q, err_d;
  logic          halt_q;
  ctl_t          ctl_q, ctl_d;
  logic          mem_st;

  assign dec_cls = (bus.ir1 == 4'b1001) ? C_CALL :
                   (bus.ir1 != 4'b1111) ? C_BR   :
                   (bus.ir2 == 3'b100)  ? C_PUSH : C_POP;

  assign mem_st = (state_q == S_FETCH1) || (state_q == S_MEMWR) || (state_q == S_MEMRD);

  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    sub_d   = sub_q;
    depth_d = depth_q;
    err_d   = err_q;
    wcnt_d  = 8'd0;
    case (state_q)
      S_RST:    state_d = S_FETCH0;
      S_FETCH0: state_d = S_FETCH1;
      S_FETCH1: if (bus.mem_rdy) state_d = S_IRLD;
      S_IRLD:   state_d = S_DECODE;
      S_DECODE: begin
        cls_d = dec_cls;
        sub_d = bus.ir2;
        // Stack limit is checked here so a failing op never touches PC or memory.
        case (dec_cls)
          C_CALL, C_PUSH: begin
            if (depth_q == DEPTH_MAX) begin
              state_d = S_ERR;
              err_d   = 2'b01;
            end else begin
              state_d = S_INCPC;
            end
          end
          C_POP: begin
            if (depth_q == '0) begin
              state_d = S_ERR;
              err_d   = 2'b10;
            end else begin
              state_d = S_INCPC;
            end
          end
          default: state_d = bus.dcond ? S_INCPC : S_FETCH0;
        endcase
      end
      S_INCPC: begin
        case (cls_q)
          C_CALL, C_PUSH: state_d = S_SPINC;
          C_POP:          state_d = S_MARSP;
          default:        state_d = S_BRT;
        endcase
      end
      S_SPINC:    state_d = (cls_q == C_CALL) ? S_MDRLD_PC : S_MDRLD_R;
      S_MDRLD_PC: state_d = S_MARSP;
      S_MDRLD_R:  state_d = S_MARSP;
      S_MARSP:    state_d = (cls_q == C_POP) ? S_MEMRD : S_MEMWR;
      S_MEMWR: begin
        if (bus.mem_rdy) begin
          state_d = (cls_q == C_CALL) ? S_BRT : S_FETCH0;
          if (depth_q != DEPTH_MAX) depth_d = depth_q + DEPTH_ONE;
        end
      end
      S_BRT:     state_d = S_BRPC;
      S_BRPC:    state_d = S_FETCH0;
      S_MEMRD:   if (bus.mem_rdy) state_d = S_MDRLD_M;
      S_MDRLD_M: state_d = S_TLD;
      S_TLD: begin
        state_d = S_SPDEC;
        if (depth_q != '0) depth_d = depth_q - DEPTH_ONE;
      end
      S_SPDEC: begin
        case (sub_q)
          3'b101:  state_d = S_POPR;
          3'b110:  state_d = S_RET;
          default: state_d = S_ALU;
        endcase
      end
      S_POPR:  state_d = S_FETCH0;
      S_RET:   state_d = S_FETCH0;
      S_ALU:   state_d = S_FETCH0;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_ERR;
    endcase

    // A ready on the final wait cycle beats the timeout.
    if (mem_st && !bus.mem_rdy) begin
      if (wcnt_q == TMO_LAST) begin
        state_d = S_ERR;
        err_d   = 2'b11;
      end else begin
        wcnt_d = wcnt_q + 8'd1;
      end
    end
  end

  always_comb begin
    ctl_d = '0;
    case (state_d)
      S_FETCH0: begin
        ctl_d.tpc   = 1'b1;
        ctl_d.ldmar = 1'b1;
        ctl_d.fnsel = FN_PASS;
      end
      S_FETCH1, S_MEMRD: begin
        ctl_d.tmar  = 1'b1;
        ctl_d.memrd = 1'b1;
      end
      S_IRLD: ctl_d.ldir = 1'b1;
      S_INCPC: begin
        ctl_d.tpc   = 1'b1;
        ctl_d.ldpc  = 1'b1;
        ctl_d.fnsel = FN_INC;
      end
      S_SPINC: begin
        ctl_d.tsp   = 1'b1;
        ctl_d.ldsp  = 1'b1;
        ctl_d.fnsel = FN_INC;
      end
      S_MDRLD_PC: begin
        ctl_d.ldmdr = 1'b1;
        ctl_d.m2    = 1'b1;
        ctl_d.tpc   = 1'b1;
        ctl_d.fnsel = FN_PASS;
      end
      S_MDRLD_R: begin
        ctl_d.ldmdr = 1'b1;
        ctl_d.m2    = 1'b1;
        ctl_d.rd    = 1'b1;
        ctl_d.fnsel = FN_PASS;
      end
      S_MARSP: begin
        ctl_d.tsp   = 1'b1;
        ctl_d.ldmar = 1'b1;
        ctl_d.fnsel = FN_PASS;
      end
      S_MEMWR: begin
        ctl_d.tmar  = 1'b1;
        ctl_d.memwr = 1'b1;
      end
      S_BRT: begin
        ctl_d.tir = 1'b1;
        ctl_d.ldt = 1'b1;
      end
      S_BRPC: begin
        ctl_d.tpc   = 1'b1;
        ctl_d.ldpc  = 1'b1;
        ctl_d.fnsel = FN_ADD;
      end
      S_MDRLD_M: ctl_d.ldmdr = 1'b1;
      S_TLD: begin
        ctl_d.tmdr = 1'b1;
        ctl_d.ldt  = 1'b1;
      end
      S_SPDEC: begin
        ctl_d.tsp   = 1'b1;
        ctl_d.ldsp  = 1'b1;
        ctl_d.fnsel = FN_DEC;
      end
      S_POPR: begin
        ctl_d.wr    = 1'b1;
        ctl_d.fnsel = FN_PASSB;
      end
      S_RET: begin
        ctl_d.ldpc  = 1'b1;
        ctl_d.fnsel = FN_PASSB;
      end
      S_ALU: begin
        ctl_d.rd = 1'b1;
        ctl_d.wr = 1'b1;
        ctl_d.m1 = 1'b1;
      end
      default: ctl_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RST;
      cls_q   <= C_BR;
      sub_q   <= 3'b000;
      wcnt_q  <= 8'd0;
      depth_q <= '0;
      err_q   <= 2'b00;
      halt_q  <= 1'b0;
      ctl_q   <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      sub_q   <= sub_d;
      wcnt_q  <= wcnt_d;
      depth_q <= depth_d;
      err_q   <= err_d;
      halt_q  <= (state_d == S_ERR);
      ctl_q   <= ctl_d;
    end
  end

  assign {bus.memwr, bus.memrd, bus.tmar, bus.ldmar, bus.tmdr, bus.ldmdr, bus.rd, bus.wr,
          bus.tsp, bus.ldsp, bus.tpc, bus.ldpc, bus.tir, bus.ldir, bus.ldt, bus.m1, bus.m2,
          bus.fnsel} = ctl_q;
  assign bus.depth = depth_q;
  assign bus.halt  = halt_q;
  assign bus.err   = err_q;
endmodule

// File: doc/mcycle_ctrl.md
MCYCLE_CTRL -- requirements
Module: mcycle_ctrl

Interface
REQ-001 Parameter DEPTH, default 16: stack capacity in words; legal range 2..255.
REQ-002 Parameter TMO, default 15: maximum wait cycles for mem_rdy; legal range 1..255.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 ir1  in  4  opcode, IR[15:12]; ir2  in  3  sub-op, IR[11:9]; dcond  in  1  branch condition.
REQ-006 mem_rdy  in  1  memory completes the access held by memrd/memwr.
REQ-007 memwr, memrd, tmar, ldmar, tmdr, ldmdr, rd, wr, tsp, ldsp, tpc, ldpc, tir, ldir, ldt, m1, m2  out  1 each  datapath strobes, one output per strobe.
REQ-008 fnsel  out  3  ALU op: 110 PASS, 100 INC, 101 DEC, 000 ADD, 111 PASSB.
REQ-009 depth  out  $clog2(DEPTH+1)  current stack occupancy.
REQ-010 halt  out  1  sticky error stop; err  out  2  cause: 01 overflow, 10 underflow, 11 timeout.

Function
REQ-011 Outputs SHALL be registered Moore decodes of the state; strobes not listed for a state SHALL be 0 and fnsel SHALL be 000.
REQ-012 FETCH0: tpc, ldmar, fnsel=PASS. Next: FETCH1.
REQ-013 FETCH1 (memory state): tmar, memrd. Next: IRLD on mem_rdy.
REQ-014 IRLD: ldir. Next: DECODE.
REQ-015 DECODE: no strobes. Branches SHALL follow REQ-016..REQ-019.
REQ-016 DECODE, ir1=1001 (CALL): INCPC, then PUSH sequence with PC source, then BRT, then BRPC, then FETCH0.
REQ-017 DECODE, ir1=1111, ir2=100 (PUSH): INCPC, then PUSH sequence with register source, then FETCH0.
REQ-018 DECODE, ir1=1111, other ir2 (POP class): INCPC, then POP sequence, then dispatch. Dispatch: ir2=101 POPR (wr, fnsel=PASSB); ir2=110 RET (ldpc, fnsel=PASSB); otherwise ALU (rd, wr, m1). All three SHALL return to FETCH0.
REQ-019 DECODE, other ir1: dcond=1 gives INCPC, BRT (tir, ldt), BRPC (tpc, ldpc, fnsel=ADD), then FETCH0; dcond=0 gives FETCH0 directly.
REQ-020 INCPC: tpc, ldpc, fnsel=INC.
REQ-021 PUSH sequence:
  - overflow check: depth==DEPTH enters ERR with err=01;
  - SPINC: tsp, ldsp, fnsel=INC;
  - MDRLD: ldmdr, m2, fnsel=PASS, plus tpc (CALL) or rd (PUSH);
  - MARSP: tsp, ldmar, fnsel=PASS;
  - MEMWR (memory state): tmar, memwr;
  - depth SHALL increment on leaving MEMWR.
REQ-022 POP sequence:
  - underflow check: depth==0 enters ERR with err=10;
  - MARSP;
  - MEMRD (memory state): tmar, memrd;
  - MDRLD: ldmdr;
  - TLD: tmdr, ldt;
  - SPDEC: tsp, ldsp, fnsel=DEC;
  - depth SHALL decrement in SPDEC.
REQ-023 The overflow/underflow check SHALL occur in the DECODE cycle. On error, INCPC and all memory strobes SHALL be suppressed.
REQ-024 Memory states SHALL hold their strobes until mem_rdy=1 is sampled, then advance on that edge.
REQ-025 Each memory state SHALL run an 8-bit wait counter cleared on entry. Reaching TMO cycles without mem_rdy SHALL enter ERR with err=11.
REQ-026 If mem_rdy=1 in the cycle the counter reaches TMO, mem_rdy SHALL win and no timeout occurs.
REQ-027 ERR: all strobes 0, halt=1, err held. ERR is exited only by reset; ir, dcond and mem_rdy SHALL be ignored.
REQ-028 With mem_rdy tied 1, each instruction class SHALL take exactly one cycle per state listed above:
  - fetch+decode: 4 cycles;
  - not-taken branch: 4;
  - taken branch: 7;
  - PUSH: 9;
  - CALL: 11;
  - POP class: 11.
REQ-029 depth SHALL never exceed DEPTH and never wrap.

Reset
REQ-030 rst_n=0 SHALL immediately clear all strobes, fnsel, depth, err and halt to 0, and set the state to FETCH0-pending, irrespective of clk.
REQ-031 The first rising clk edge with rst_n=1 SHALL present FETCH0 outputs. Reset asserted mid-sequence (including inside a memory wait) SHALL abandon the sequence with no further strobes.

Verification
REQ-032 Fetch, mem_rdy=1, ir1=0000, dcond=0 -> FETCH0/FETCH1/IRLD/DECODE strobes in successive cycles, then FETCH0 on cycle 5.
REQ-033 CALL (ir1=1001), mem_rdy=1, depth=0 -> strobe sequence per REQ-016; depth=1 after MEMWR; BRPC asserts tpc, ldpc, fnsel=000.
REQ-034 DEPTH=2: PUSH, PUSH, PUSH -> third push enters ERR with err=01, halt=1, no memwr; depth remains 2.
REQ-035 Reset, then POP-class (ir1=1111, ir2=000) -> ERR with err=10 in the cycle after DECODE; no ldpc.
REQ-036 TMO=3, mem_rdy held 0 in FETCH1 -> memrd high for 3 cycles, then err=11, halt=1. Variant: mem_rdy=1 on the 3rd wait cycle -> IRLD, no error.
REQ-037 rst_n pulled low during a MEMWR wait -> memwr drops asynchronously, depth unchanged at 0; after release, FETCH0 follows.
